// File: rtl/tt_pkg.sv
// Shared types and helpers for the truth-table sweeper.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package tt_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        SAMPLE,
        FINISH
    } tt_state_e;

    // Default expected table: F = A' + BC, bit i = F(stim==i).
    localparam logic [7:0] EXP_DEFAULT = 8'h8F;

    // Widest table lowest_set() can scan (N_IN up to 8).
    localparam int LS_W = 256;

    // Index of the lowest set bit of v; 0 when v is all zeros.
    function automatic logic [7:0] lowest_set(input logic [LS_W-1:0] v);
        lowest_set = '0;
        for (int i = LS_W - 1; i >= 0; i--) begin
            if (v[i]) begin
                lowest_set = 8'(i);
            end
        end
    endfunction

endpackage

// File: rtl/tt_settle_counter.sv
// Loadable settle down-counter with a zero flag; reload value derived from SETTLE.
// Latency: load/decrement take effect on the next rising edge; zero_o is combinational from the count.
// Backpressure: none; decrement saturates at zero.
module tt_settle_counter #(
    parameter int SETTLE = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    input  logic dec_i,
    output logic zero_o
);

    // The load edge itself is one cycle of the hold, so reload with SETTLE-1.
    localparam logic [3:0] RELOAD = (SETTLE == 0) ? 4'd0 : 4'(SETTLE - 1);

    logic [3:0] cnt_q;

    // Count register: load has priority over decrement; stop at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 4'd0;
        end else if (load_i) begin
            cnt_q <= RELOAD;
        end else if (dec_i && (cnt_q != 4'd0)) begin
            cnt_q <= cnt_q - 4'd1;
        end
    end

    assign zero_o = (cnt_q == 4'd0);

endmodule

// File: rtl/truth_table_sweeper.sv
// Sweeps every input combination onto a combinational DUT, captures y into a truth table and grades it.
// Latency: SETTLE+1 cycles per vector; done pulses in cycle 2**N_IN*(SETTLE+1)+1 after the start-accept edge.
// Backpressure: none; start is only looked at in IDLE and is dropped otherwise. Option: TT_DUAL_DUT_EN.
module truth_table_sweeper
    import tt_pkg::*;
#(
    parameter int                  N_IN     = 3,
    parameter int                  SETTLE   = 2,
    parameter logic [2**N_IN-1:0]  EXPECTED = EXP_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 y,
`ifdef TT_DUAL_DUT_EN
    input  logic                 y_b,
    output logic [2**N_IN-1:0]   table_b_q,
    output logic                 agree,
`endif
    output logic [N_IN-1:0]      stim,
    output logic                 busy,
    output logic                 done,
    output logic [2**N_IN-1:0]   table_q,
    output logic                 pass,
    output logic [N_IN-1:0]      first_fail
);

    localparam int TW = 2**N_IN;
    // With no settle time the first vector is sampled in its apply cycle.
    localparam tt_state_e VEC_ST = (SETTLE == 0) ? SAMPLE : DRIVE;

    tt_state_e            state_q;
    logic [N_IN:0]        idx_q;      // one spare bit: the sweep ends on compare, never on wrap
    logic [N_IN-1:0]      stim_q;
    logic                 busy_q;
    logic                 done_q;
    logic [TW-1:0]        tbl_q;
    logic                 pass_q;
    logic [N_IN-1:0]      ff_q;
    logic [TW-1:0]        tbl_nxt;
    logic [N_IN-1:0]      ff_nxt;
    logic                 last;
    logic                 cnt_zero;
    logic                 cnt_load;
    logic                 cnt_dec;
`ifdef TT_DUAL_DUT_EN
    logic [TW-1:0]        tblb_q;
    logic [TW-1:0]        tblb_nxt;
    logic                 agree_q;
`endif

    assign last     = (idx_q == (N_IN+1)'(TW - 1));
    assign cnt_load = ((state_q == IDLE) && start) || ((state_q == SAMPLE) && !last);
    assign cnt_dec  = (state_q == DRIVE);

    tt_settle_counter #(
        .SETTLE (SETTLE)
    ) u_settle (
        .clk    (clk),
        .rst    (rst),
        .load_i (cnt_load),
        .dec_i  (cnt_dec),
        .zero_o (cnt_zero)
    );

    // Table as it will look after this cycle's sample, so grading can happen on the final sample edge.
    always_comb begin
        tbl_nxt = tbl_q;
        tbl_nxt[idx_q[N_IN-1:0]] = y;
`ifdef TT_DUAL_DUT_EN
        tblb_nxt = tblb_q;
        tblb_nxt[idx_q[N_IN-1:0]] = y_b;
`endif
    end

    assign ff_nxt = N_IN'(lowest_set(LS_W'(tbl_nxt ^ EXPECTED)));

    // Sweep FSM with registered outputs; done/pass/first_fail land as FINISH is entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            stim_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            tbl_q   <= '0;
            pass_q  <= 1'b0;
            ff_q    <= '0;
`ifdef TT_DUAL_DUT_EN
            tblb_q  <= '0;
            agree_q <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        idx_q   <= '0;
                        stim_q  <= '0;
                        tbl_q   <= '0;
                        pass_q  <= 1'b0;
                        ff_q    <= '0;
                        busy_q  <= 1'b1;
`ifdef TT_DUAL_DUT_EN
                        tblb_q  <= '0;
                        agree_q <= 1'b0;
`endif
                        state_q <= VEC_ST;
                    end
                end
                DRIVE: begin
                    if (cnt_zero) begin
                        state_q <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    tbl_q <= tbl_nxt;
`ifdef TT_DUAL_DUT_EN
                    tblb_q <= tblb_nxt;
`endif
                    if (last) begin
                        pass_q  <= (tbl_nxt == EXPECTED);
                        ff_q    <= ff_nxt;
`ifdef TT_DUAL_DUT_EN
                        agree_q <= (tbl_nxt == tblb_nxt);
`endif
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= FINISH;
                    end else begin
                        idx_q   <= idx_q + 1'b1;
                        stim_q  <= stim_q + 1'b1;
                        state_q <= VEC_ST;
                    end
                end
                FINISH: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign stim       = stim_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign table_q    = tbl_q;
    assign pass       = pass_q;
    assign first_fail = ff_q;
`ifdef TT_DUAL_DUT_EN
    assign table_b_q  = tblb_q;
    assign agree      = agree_q;
`endif

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper: vector table of DUT models plus corner-case sequences.
// Latency: n/a.
// Backpressure: n/a.
module tb_truth_table_sweeper;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, start0;
    logic       y, y0;
    logic [2:0] stim, stim0;
    logic       busy, busy0, done, done0;
    logic [7:0] tbl, tbl0;
    logic       pass, pass0;
    logic [2:0] ff, ff0;
    int         mode;
`ifdef TT_DUAL_DUT_EN
    logic       y_b, y_b0, flt_b;
    logic [7:0] tbl_b, tbl_b0;
    logic       agree, agree0;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Reference gate functions; A = s[2], B = s[1], C = s[0].
    function automatic logic model(input int m, input logic [2:0] s);
        case (m)
            0:       model = ~s[2] | (s[1] & s[0]);
            1:       model = ~s[2];
            2:       model = 1'b0;
            3:       model = 1'b1;
            default: model = ~s[2] | s[0];
        endcase
    endfunction

    assign y  = model(mode, stim);
    assign y0 = model(0, stim0);
`ifdef TT_DUAL_DUT_EN
    assign y_b  = (flt_b && stim == 3'd2) ? 1'b0 : model(0, stim);
    assign y_b0 = y0;
`endif

    truth_table_sweeper #(.N_IN(3), .SETTLE(2)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .y          (y),
`ifdef TT_DUAL_DUT_EN
        .y_b        (y_b),
        .table_b_q  (tbl_b),
        .agree      (agree),
`endif
        .stim       (stim),
        .busy       (busy),
        .done       (done),
        .table_q    (tbl),
        .pass       (pass),
        .first_fail (ff)
    );

    truth_table_sweeper #(.N_IN(3), .SETTLE(0)) u_dut0 (
        .clk        (clk),
        .rst        (rst),
        .start      (start0),
        .y          (y0),
`ifdef TT_DUAL_DUT_EN
        .y_b        (y_b0),
        .table_b_q  (tbl_b0),
        .agree      (agree0),
`endif
        .stim       (stim0),
        .busy       (busy0),
        .done       (done0),
        .table_q    (tbl0),
        .pass       (pass0),
        .first_fail (ff0)
    );

    typedef struct {
        int         mode;
        logic [7:0] tbl;
        logic       pass;
        logic [2:0] ff;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One sweep on the SETTLE=2 instance. lat = cycle number (accept-edge cycle is 1) in which done is seen;
    // serr counts cycles where stim or busy deviated from the expected hold pattern.
    task automatic run_sweep(output int lat, output int serr);
        lat  = -1;
        serr = 0;
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1;
        for (int e = 0; e < 100; e++) begin
            if (e > 0) begin
                @(posedge clk);
                #1;
            end
            if (done) begin
                lat = e + 1;
                break;
            end
            if (stim !== 3'(e / 3) || busy !== 1'b1) serr++;
            if (e == 0) start = 1'b0;
        end
    endtask

    initial begin
        int lat, serr, e1, e2, ndone, found;

        vecs[0] = '{0, 8'h8F, 1'b1, 3'd0};   // golden A' + BC
        vecs[1] = '{1, 8'h0F, 1'b0, 3'd7};   // drops BC term
        vecs[2] = '{2, 8'h00, 1'b0, 3'd0};   // stuck at 0
        vecs[3] = '{3, 8'hFF, 1'b0, 3'd4};   // stuck at 1
        vecs[4] = '{4, 8'hAF, 1'b0, 3'd5};   // A' + C

        mode   = 0;
        rst    = 1'b1;
        start  = 1'b0;
        start0 = 1'b0;
`ifdef TT_DUAL_DUT_EN
        flt_b  = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("rst_stim", stim, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_table", tbl, 0);
        check("rst_pass", pass, 0);
        check("rst_first_fail", ff, 0);
        @(negedge clk) rst = 1'b0;
        repeat (2) @(posedge clk);

        // Table-driven sweeps over the model set.
        for (int i = 0; i < 5; i++) begin
            mode = vecs[i].mode;
            run_sweep(lat, serr);
            check($sformatf("v%0d_latency", i), lat, 25);
            check($sformatf("v%0d_stim_hold", i), serr, 0);
            check($sformatf("v%0d_busy_at_done", i), busy, 0);
            check($sformatf("v%0d_table", i), tbl, vecs[i].tbl);
            check($sformatf("v%0d_pass", i), pass, vecs[i].pass);
            check($sformatf("v%0d_first_fail", i), ff, vecs[i].ff);
            @(posedge clk);
            #1;
            check($sformatf("v%0d_done_pulse", i), done, 0);
            repeat (2) @(posedge clk);
            #1;
            check($sformatf("v%0d_table_hold", i), tbl, vecs[i].tbl);
        end

        // start held high: back-to-back sweeps, one IDLE cycle between them.
        mode = 0;
        e1 = -1;
        e2 = -1;
        @(negedge clk) start = 1'b1;
        for (int e = 0; e < 120; e++) begin
            @(posedge clk);
            #1;
            if (done) begin
                if (e1 < 0) e1 = e;
                else begin
                    e2 = e;
                    break;
                end
            end
        end
        @(negedge clk) start = 1'b0;
        check("b2b_first_done", e1, 24);
        check("b2b_gap", e2 - e1, 26);
        repeat (3) @(posedge clk);
        #1;
        check("b2b_idle_after", busy, 0);

        // Reset mid-sweep at stim==4.
        found = 0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(posedge clk);
            #1;
            if (stim == 3'd4) begin
                found = 1;
                break;
            end
        end
        check("mid_rst_reached_stim4", found, 1);
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_stim", stim, 0);
        check("mid_rst_table", tbl, 0);
        check("mid_rst_done", done, 0);
        @(negedge clk) rst = 1'b0;
        ndone = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        check("mid_rst_no_done", ndone, 0);
        run_sweep(lat, serr);
        check("post_rst_latency", lat, 25);
        check("post_rst_table", tbl, 8'h8F);
        check("post_rst_pass", pass, 1);

        // start and rst in the same cycle: reset wins.
        @(negedge clk) begin
            rst   = 1'b1;
            start = 1'b1;
        end
        @(posedge clk);
        #1;
        check("rst_vs_start_busy", busy, 0);
        check("rst_vs_start_pass", pass, 0);
        @(negedge clk) begin
            rst   = 1'b0;
            start = 1'b0;
        end
        @(posedge clk);
        #1;
        check("rst_vs_start_idle", busy, 0);

        // SETTLE=0 instance: one cycle per vector.
        lat  = -1;
        serr = 0;
        @(negedge clk) start0 = 1'b1;
        @(posedge clk);
        #1;
        for (int e = 0; e < 40; e++) begin
            if (e > 0) begin
                @(posedge clk);
                #1;
            end
            if (done0) begin
                lat = e + 1;
                break;
            end
            if (stim0 !== 3'(e)) serr++;
            if (e == 0) start0 = 1'b0;
        end
        check("s0_latency", lat, 9);
        check("s0_stim_step", serr, 0);
        check("s0_table", tbl0, 8'h8F);
        check("s0_pass", pass0, 1);
        check("s0_first_fail", ff0, 0);

`ifdef TT_DUAL_DUT_EN
        mode  = 0;
        flt_b = 1'b0;
        run_sweep(lat, serr);
        check("dual_agree", agree, 1);
        check("dual_table_b", tbl_b, 8'h8F);
        flt_b = 1'b1;
        run_sweep(lat, serr);
        check("dual_fault_agree", agree, 0);
        check("dual_fault_pass", pass, 1);
        check("dual_fault_table_b", tbl_b, 8'h8B);
        flt_b = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
